// File: rtl/neuron_param_sequencer.sv
// Purpose: shifts tau/weight/threshold words LSB-first into the LIF neuron's serial parameter loader.
// Latency: set_vars_o rises 1 cycle after the handshake, done follows the last of TAU_W shift cycles.
// Backpressure: cfg_ready is high only in IDLE; requests wait (no queueing) while a load is in flight.
module neuron_param_sequencer #(
    parameter int               TAU_W   = 15,
    parameter int               WGT_W   = 11,
    parameter int               GAP     = 2,
    parameter logic [TAU_W-1:0] DEF_TAU = 15'd8,
    parameter logic [WGT_W-1:0] DEF_WGT = 11'd4,
    parameter logic [TAU_W-1:0] DEF_THR = 15'd64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [TAU_W-1:0] cfg_tau,
    input  logic [WGT_W-1:0] cfg_weight,
    input  logic [TAU_W-1:0] cfg_thresh,
    input  logic             abort,
    output logic             set_vars_o,
    output logic             expd_o,
    output logic             w_o,
    output logic             t_o,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int CW = (TAU_W > 1) ? $clog2(TAU_W) : 1;
    localparam int GW = $clog2(GAP + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(TAU_W - 1);

    typedef enum logic [2:0] {
        S_DEFAULT,
        S_IDLE,
        S_SHIFT,
        S_COMMIT,
        S_GAP
    } state_t;

    state_t           state, state_nxt;
    logic [TAU_W-1:0] tau_sr, tau_nxt;
    logic [WGT_W-1:0] wgt_sr, wgt_nxt;
    logic [TAU_W-1:0] thr_sr, thr_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [GW-1:0]    gap_left, gap_left_nxt;
    logic             done_nxt, aborted_nxt;
    logic             shifting_nxt;

    always_comb begin
        state_nxt    = state;
        tau_nxt      = tau_sr;
        wgt_nxt      = wgt_sr;
        thr_nxt      = thr_sr;
        bit_cnt_nxt  = bit_cnt;
        gap_left_nxt = gap_left;
        done_nxt     = 1'b0;
        aborted_nxt  = 1'b0;

        case (state)
            S_DEFAULT: begin
                tau_nxt     = DEF_TAU;
                wgt_nxt     = DEF_WGT;
                thr_nxt     = DEF_THR;
                bit_cnt_nxt = '0;
                state_nxt   = S_SHIFT;
            end
            S_IDLE: begin
                if (cfg_valid) begin
                    tau_nxt     = cfg_tau;
                    wgt_nxt     = cfg_weight;
                    thr_nxt     = cfg_thresh;
                    bit_cnt_nxt = '0;
                    state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The aborted cycle is the first low cycle, so the full GAP is spent in S_GAP.
                if (abort) begin
                    state_nxt    = S_GAP;
                    gap_left_nxt = GW'(GAP);
                    aborted_nxt  = 1'b1;
                end else if (bit_cnt == LAST_BIT) begin
                    state_nxt = S_COMMIT;
                    done_nxt  = 1'b1;
                end else begin
                    tau_nxt     = tau_sr >> 1;
                    wgt_nxt     = wgt_sr >> 1;
                    thr_nxt     = thr_sr >> 1;
                    bit_cnt_nxt = bit_cnt + CW'(1);
                end
            end
            S_COMMIT: begin
                if (GAP <= 1) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt    = S_GAP;
                    gap_left_nxt = GW'(GAP - 1);
                end
            end
            S_GAP: begin
                if (gap_left <= GW'(1)) begin
                    state_nxt    = S_IDLE;
                    gap_left_nxt = '0;
                end else begin
                    gap_left_nxt = gap_left - GW'(1);
                end
            end
            default: state_nxt = S_DEFAULT;
        endcase

        shifting_nxt = (state_nxt == S_SHIFT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_DEFAULT;
            tau_sr   <= '0;
            wgt_sr   <= '0;
            thr_sr   <= '0;
            bit_cnt  <= '0;
            gap_left <= '0;
        end else begin
            state    <= state_nxt;
            tau_sr   <= tau_nxt;
            wgt_sr   <= wgt_nxt;
            thr_sr   <= thr_nxt;
            bit_cnt  <= bit_cnt_nxt;
            gap_left <= gap_left_nxt;
        end
    end

    // Outputs are flopped from next-state values so they line up with the state they describe;
    // the weight register shifts in zeros, which blanks w_o once its WGT_W bits are exhausted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_vars_o <= 1'b0;
            expd_o     <= 1'b0;
            w_o        <= 1'b0;
            t_o        <= 1'b0;
            cfg_ready  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            set_vars_o <= shifting_nxt;
            expd_o     <= shifting_nxt & tau_nxt[0];
            w_o        <= shifting_nxt & wgt_nxt[0];
            t_o        <= shifting_nxt & thr_nxt[0];
            cfg_ready  <= (state_nxt == S_IDLE);
            busy       <= (state_nxt != S_IDLE);
            done       <= done_nxt;
            aborted    <= aborted_nxt;
        end
    end

endmodule

// File: tb/tb_neuron_param_sequencer.sv
// Directed bench for neuron_param_sequencer with a serial-loader capture model.
// Inputs change 1 time unit after posedge; outputs are sampled at that same point.
module tb_neuron_param_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [14:0] cfg_tau = '0;
    logic [10:0] cfg_weight = '0;
    logic [14:0] cfg_thresh = '0;
    logic        abort = 1'b0;
    logic        set_vars_o, expd_o, w_o, t_o, busy, done, aborted;

    int n_assert = 0;
    int n_fail   = 0;

    neuron_param_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_tau    (cfg_tau),
        .cfg_weight (cfg_weight),
        .cfg_thresh (cfg_thresh),
        .abort      (abort),
        .set_vars_o (set_vars_o),
        .expd_o     (expd_o),
        .w_o        (w_o),
        .t_o        (t_o),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for cfg_ready, present one word set for exactly one handshake cycle.
    task automatic handshake(input logic [14:0] t, input logic [10:0] w, input logic [14:0] th);
        int k = 0;
        while (cfg_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk("ready_wait", {31'd0, cfg_ready}, 32'd1);
        cfg_valid  = 1'b1;
        cfg_tau    = t;
        cfg_weight = w;
        cfg_thresh = th;
        tick();
        cfg_valid  = 1'b0;
        cfg_tau    = 15'($urandom);
        cfg_weight = 11'($urandom);
        cfg_thresh = 15'($urandom);
    endtask

    // Called in the c=0 shift cycle; plays the loader, collecting one bit per set_vars cycle.
    task automatic capture(input int abort_at, output logic [14:0] gt, output logic [14:0] gw,
                           output logic [14:0] gth, output bit was_aborted);
        gt = '0;
        gw = '0;
        gth = '0;
        was_aborted = 1'b0;
        for (int c = 0; c < 15; c++) begin
            chk("set_vars_hi", {31'd0, set_vars_o}, 32'd1);
            chk("ready_lo_shift", {31'd0, cfg_ready}, 32'd0);
            chk("no_pulse_shift", {30'd0, done, aborted}, 32'd0);
            gt[c]  = expd_o;
            gw[c]  = w_o;
            gth[c] = t_o;
            if (c == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_sv_lo", {31'd0, set_vars_o}, 32'd0);
                chk("abort_pulse", {31'd0, aborted}, 32'd1);
                chk("abort_no_done", {31'd0, done}, 32'd0);
                chk("abort_lines_lo", {29'd0, expd_o, w_o, t_o}, 32'd0);
                was_aborted = 1'b1;
                return;
            end
            tick();
        end
        chk("commit_sv_lo", {31'd0, set_vars_o}, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("commit_no_abort", {31'd0, aborted}, 32'd0);
        chk("commit_lines_lo", {29'd0, expd_o, w_o, t_o}, 32'd0);
    endtask

    // Called in the done/aborted cycle: one more low busy cycle, then IDLE.
    task automatic gap_then_idle();
        tick();
        chk("gap_sv_lo", {31'd0, set_vars_o}, 32'd0);
        chk("gap_ready_lo", {31'd0, cfg_ready}, 32'd0);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        chk("gap_pulses_lo", {30'd0, done, aborted}, 32'd0);
        tick();
        chk("idle_ready", {31'd0, cfg_ready}, 32'd1);
        chk("idle_busy_lo", {31'd0, busy}, 32'd0);
        chk("idle_sv_lo", {31'd0, set_vars_o}, 32'd0);
    endtask

    task automatic chk_words(input string tag, input logic [14:0] gt, input logic [14:0] gw,
                             input logic [14:0] gth, input logic [14:0] et,
                             input logic [10:0] ew, input logic [14:0] eth);
        chk({tag, "_tau"}, {17'd0, gt}, {17'd0, et});
        chk({tag, "_wgt"}, {17'd0, gw}, {21'd0, ew});
        chk({tag, "_thr"}, {17'd0, gth}, {17'd0, eth});
    endtask

    initial begin
        logic [14:0] gt, gw, gth;
        logic [14:0] rt, rth;
        logic [10:0] rw;
        bit          ab_run;
        int          ab_at;

        // Reset state
        #12;
        chk("rst_sv", {31'd0, set_vars_o}, 32'd0);
        chk("rst_lines", {29'd0, expd_o, w_o, t_o}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_pulses", {30'd0, done, aborted}, 32'd0);

        // 1: automatic default load
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("default_cycle_sv", {31'd0, set_vars_o}, 32'd0);
        chk("default_cycle_ready", {31'd0, cfg_ready}, 32'd0);
        tick();
        capture(-1, gt, gw, gth, ab_run);
        chk_words("defaults", gt, gw, gth, 15'd8, 11'd4, 15'd64);
        gap_then_idle();

        // 2: patterned host word
        handshake(15'h5A5A, 11'h7FF, 15'h0001);
        capture(-1, gt, gw, gth, ab_run);
        chk_words("pattern", gt, gw, gth, 15'h5A5A, 11'h7FF, 15'h0001);
        gap_then_idle();

        // 3: cfg_valid held through a load; second word set waits for IDLE
        cfg_valid  = 1'b1;
        cfg_tau    = 15'h1234;
        cfg_weight = 11'h0AB;
        cfg_thresh = 15'h7001;
        tick();
        cfg_tau    = 15'h0F0F;
        cfg_weight = 11'h555;
        cfg_thresh = 15'h4000;
        capture(-1, gt, gw, gth, ab_run);
        chk_words("held_first", gt, gw, gth, 15'h1234, 11'h0AB, 15'h7001);
        gap_then_idle();
        tick();
        cfg_valid = 1'b0;
        capture(-1, gt, gw, gth, ab_run);
        chk_words("held_second", gt, gw, gth, 15'h0F0F, 11'h555, 15'h4000);
        gap_then_idle();

        // 4: abort at c=6, then abort while idle
        handshake(15'h7FFF, 11'h7FF, 15'h7FFF);
        capture(6, gt, gw, gth, ab_run);
        chk("abort_partial_tau", {17'd0, gt}, 32'h007F);
        gap_then_idle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ready", {31'd0, cfg_ready}, 32'd1);
        chk("idle_abort_busy", {31'd0, busy}, 32'd0);
        chk("idle_abort_pulse", {31'd0, aborted}, 32'd0);
        chk("idle_abort_sv", {31'd0, set_vars_o}, 32'd0);

        // 5: reset at c=9, default load reruns
        handshake(15'h1111, 11'h222, 15'h3333);
        repeat (9) tick();
        chk("pre_rst_sv", {31'd0, set_vars_o}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_sv", {31'd0, set_vars_o}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd1);
        chk("async_rst_ready", {31'd0, cfg_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rerun_default_cycle", {31'd0, set_vars_o}, 32'd0);
        tick();
        capture(-1, gt, gw, gth, ab_run);
        chk_words("rerun_defaults", gt, gw, gth, 15'd8, 11'd4, 15'd64);
        gap_then_idle();

        // 6: random words with random aborts
        for (int i = 0; i < 200; i++) begin
            rt    = 15'($urandom);
            rw    = 11'($urandom);
            rth   = 15'($urandom);
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
            handshake(rt, rw, rth);
            capture(ab_at, gt, gw, gth, ab_run);
            if (!ab_run) chk_words("random", gt, gw, gth, rt, rw, rth);
            gap_then_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
